ysyx_25040111_mem_arb: RTL and testbench
========================================

Name: ysyx_25040111_mem_arb

Overview:
Sequential arbiter sharing the single LSU/AXI memory master between the icache refill port (I, read bursts) and the data port (D, single-beat load/store).
Replaces the combinational if_flag mux in the core top.
Latches the granted request and issues a one-cycle start pulse downstream.
Steers returned beats and completion to the owner, and holds the grant until the transaction completes.

Parameters:
PRIO_MODE, 0, 0 = round-robin between I and D; 1 = fixed priority, D wins.
TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with the optional feature).

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
i_req  in  1  icache refill request, level, held until i_done
i_addr  in  32  burst base address
i_len  in  8  AXI-style burst length (beats-1)
i_rdata  out  32  beat data to icache
i_rvalid  out  1  beat valid to icache
i_beat  out  8  index of current beat
i_done  out  1  one-cycle completion pulse to icache
d_req  in  1  data request, level, held until d_done
d_wen  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_size  in  2  access size, LSU mask encoding
d_sign  in  1  sign-extend load
d_rdata  out  32  load result
d_done  out  1  one-cycle completion pulse
d_err  out  1  error flag, valid with d_done
m_start  out  1  one-cycle start pulse to LSU
m_wen  out  1  write enable to LSU
m_ren  out  1  read enable to LSU
m_addr  out  32  address to LSU
m_wdata  out  32  write data to LSU
m_size  out  2  access size to LSU
m_sign  out  1  sign flag to LSU
m_len  out  8  burst length to LSU
m_rdata  in  32  read beat data
m_rvalid  in  1  read beat valid
m_done  in  1  transaction complete (same cycle as last beat for reads)

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Registered outputs; every output is 0 after reset.
- IDLE:
  - Sample i_req/d_req. If neither, stay.
  - If exactly one, grant it.
  - If both: PRIO_MODE=1 grants D. PRIO_MODE=0 grants the port not granted last; last_grant resets to I, so D wins the first tie.
  - Latch owner fields into m_* registers; go to ISSUE.
- ISSUE: m_start=1 for exactly this cycle; go to WAIT. Latency is req seen at cycle t -> m_start at t+1.
- I grant: m_ren=1, m_wen=0, m_size=2'b11, m_sign=0, m_len=i_len.
- D grant: m_ren=~d_wen, m_wen=d_wen, m_size=d_size, m_sign=d_sign, m_len=0.
- WAIT, owner I:
  - Each m_rvalid -> i_rvalid=1 the same cycle, i_rdata=m_rdata, i_beat=beat counter.
  - Beat counter increments per beat and clears on grant.
- WAIT, owner D: on m_done, d_rdata=m_rdata for loads (0 for stores).
- Completion: m_done -> owner's done pulses combinationally the same cycle, last_grant updated, next state IDLE.
  - A new grant can be taken on the cycle after done.
  - Minimum 3-cycle spacing between m_start pulses.
- Beat mismatch: m_done on an I burst with beat count != i_len+1 sets d_err=0 and raises no I error. In simulation, an $error is emitted.
- m_rvalid/m_done while IDLE/ISSUE are ignored.
- Requests dropped mid-transaction do not abort it; done still pulses to the original owner.
- No preemption: a burst blocks D until m_done.
- reset in any state: return to IDLE, clear the latched request, the beat counter and last_grant. The downstream LSU is reset by the same signal.
- m_* fields are stable from ISSUE through WAIT.

Optional Feature:
- Macro YSYX_25040111_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT, cleared on entry.
  - Reaching TIMEOUT_CYC forces the owner's done pulse and returns to IDLE.
  - For D, d_err=1. For I, i_done is forced with i_rvalid=0.
  - A late m_done after timeout is ignored in IDLE.
- Undefined: no counter; WAIT persists until m_done; d_err is tied 0.

Decomposition:
- Shared package/header (ysyx_25040111_inc.vh): state encoding, owner encoding (OWN_I, OWN_D), size encoding for word (2'b11), and the default TIMEOUT_CYC width macro.
- Sub-module: ysyx_25040111_rr_pick, a 2-way round-robin/priority picker with last_grant register. Everything else stays in the top module.

Test Plan:
- Single D store (d_req, d_wen=1, addr 0x8000_0010, data 0xDEADBEEF) -> m_start one cycle later with m_wen=1, m_len=0; m_done after 5 cycles -> d_done same cycle, d_err=0.
- I burst, i_len=3, addr 0x3000_0000, 4 m_rvalid beats 0x11..0x44 -> i_rvalid x4, i_beat 0..3, i_done on the 4th beat; d_req raised mid-burst is granted only after i_done.
- Simultaneous i_req & d_req repeatedly, PRIO_MODE=0 -> grants D, I, D, I; PRIO_MODE=1 -> D every time while d_req is held.
- reset asserted during WAIT of an I burst -> next cycle all outputs 0, state IDLE, beat counter 0; a stray m_done afterward produces no done pulse.
- With YSYX_25040111_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, a D load with no m_done -> d_done with d_err=1 at the 16th WAIT cycle; a later m_done is ignored.
- D load with d_size=2'b00, d_sign=1 -> m_size=00, m_sign=1, m_ren=1; m_rdata 0xFFFFFF80 is returned on d_rdata.

Source files
------------

// File: rtl/ysyx_25040111_mem_arb_pkg.sv
// Shared definitions for the LSU/AXI memory arbiter: FSM state encoding,
// owner encoding, the word access size and counter sizing helpers.
package ysyx_25040111_mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } arb_owner_e;

  // LSU mask encoding for a full 32-bit word.
  localparam logic [1:0] SizeWord = 2'b11;

  // Wide enough to count 256 beats of a maximal burst.
  localparam int unsigned BeatCntW = 9;

  // Width of a counter that must reach `limit`.
  function automatic int unsigned cnt_width(int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ysyx_25040111_rr_pick.sv
// Two-way request picker for the memory arbiter.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   i_req_i/d_req_i requests from the icache and data ports
//   update_i        transaction completed this cycle; record its owner
//   done_d_i        owner of the completing transaction (1 = D)
//   grant_valid_o   at least one request present
//   grant_d_o       winner (1 = D, 0 = I)
// PrioMode 0 alternates on a tie, PrioMode 1 always prefers D.
module ysyx_25040111_rr_pick #(
  parameter int unsigned PrioMode = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic update_i,
  input  logic done_d_i,
  output logic grant_valid_o,
  output logic grant_d_o
);

  // Resets to "I was last", so D wins the first tie.
  logic last_d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_d_q <= 1'b0;
    end else if (update_i) begin
      last_d_q <= done_d_i;
    end
  end

  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    if (i_req_i && d_req_i) begin
      grant_d_o = (PrioMode != 0) ? 1'b1 : ~last_d_q;
    end else begin
      grant_d_o = d_req_i;
    end
  end

endmodule

// File: rtl/ysyx_25040111_mem_arb.sv
// Sequential arbiter sharing one LSU/AXI master between the icache refill
// port (I, read bursts) and the data port (D, single-beat load/store).
// Ports:
//   clock, reset       clock, synchronous active-high reset
//   i_req/i_addr/i_len icache burst request; i_rdata/i_rvalid/i_beat/i_done back
//   d_req/d_wen/d_addr/d_wdata/d_size/d_sign  data request; d_rdata/d_done/d_err back
//   m_start/m_wen/m_ren/m_addr/m_wdata/m_size/m_sign/m_len  registered LSU command
//   m_rdata/m_rvalid/m_done  LSU response
// Optional feature: define YSYX_25040111_ARB_TIMEOUT_EN to add a WAIT watchdog
// that forces completion after TIMEOUT_CYC cycles (D reports d_err).
module ysyx_25040111_mem_arb
  import ysyx_25040111_mem_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE   = 0,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic [7:0]  i_beat,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        m_start,
  output logic        m_wen,
  output logic        m_ren,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  output logic        m_sign,
  output logic [7:0]  m_len,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_done
);

  if (TIMEOUT_CYC == 0) begin : gen_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q;
  logic [BeatCntW-1:0] beat_q;
  logic                grant_valid, grant_d, take_grant;
  logic                timeout_hit, done_hit;

  ysyx_25040111_rr_pick #(
    .PrioMode(PRIO_MODE)
  ) u_pick (
    .clk_i        (clock),
    .rst_i        (reset),
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .update_i     (done_hit),
    .done_d_i     (owner_q == OwnD),
    .grant_valid_o(grant_valid),
    .grant_d_o    (grant_d)
  );

  assign take_grant = (state_q == StIdle) && grant_valid;

`ifdef YSYX_25040111_ARB_TIMEOUT_EN
  localparam int unsigned ToW = cnt_width(TIMEOUT_CYC);
  logic [ToW-1:0] to_cnt_q;

  // Held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge clock) begin
    if (reset || state_q != StWait) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + ToW'(1);
    end
  end

  // A real m_done on the deadline cycle wins over the watchdog.
  assign timeout_hit = (state_q == StWait) && !m_done && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign done_hit = (state_q == StWait) && (m_done || timeout_hit);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (done_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Latched command; held unchanged until the next grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= OwnI;
      beat_q  <= '0;
      m_start <= 1'b0;
      m_wen   <= 1'b0;
      m_ren   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_size  <= '0;
      m_sign  <= 1'b0;
      m_len   <= '0;
    end else begin
      m_start <= take_grant;
      if (take_grant) begin
        beat_q <= '0;
        if (grant_d) begin
          owner_q <= OwnD;
          m_wen   <= d_wen;
          m_ren   <= ~d_wen;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          m_size  <= d_size;
          m_sign  <= d_sign;
          m_len   <= '0;
        end else begin
          owner_q <= OwnI;
          m_wen   <= 1'b0;
          m_ren   <= 1'b1;
          m_addr  <= i_addr;
          m_wdata <= '0;
          m_size  <= SizeWord;
          m_sign  <= 1'b0;
          m_len   <= i_len;
        end
      end else if (state_q == StWait && owner_q == OwnI && m_rvalid) begin
        beat_q <= beat_q + BeatCntW'(1);
      end
    end
  end

  // Response steering: combinational so beats and done reach the owner in the
  // same cycle the LSU presents them.
  always_comb begin
    i_rdata  = '0;
    i_rvalid = 1'b0;
    i_beat   = '0;
    i_done   = 1'b0;
    d_rdata  = '0;
    d_done   = 1'b0;
    d_err    = 1'b0;
    if (state_q == StWait) begin
      if (owner_q == OwnI) begin
        if (m_rvalid && !timeout_hit) begin
          i_rvalid = 1'b1;
          i_rdata  = m_rdata;
          i_beat   = beat_q[7:0];
        end
        i_done = done_hit;
      end else begin
        d_done = done_hit;
        if (m_done && !m_wen) d_rdata = m_rdata;
        d_err = timeout_hit;
      end
    end
  end

`ifndef SYNTHESIS
  // The final beat arrives together with m_done, so count it in.
  logic [BeatCntW-1:0] beats_seen;
  assign beats_seen = beat_q + BeatCntW'(m_rvalid);

  always_ff @(posedge clock) begin
    if (!reset && state_q == StWait && owner_q == OwnI && m_done) begin
      assert (beats_seen == BeatCntW'(m_len) + BeatCntW'(1))
        else $error("mem_arb: burst ended after %0d beats, expected %0d", beats_seen, m_len + 1);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25040111_mem_arb.sv
module tb_ysyx_25040111_mem_arb;
  import ysyx_25040111_mem_arb_pkg::*;

  localparam int unsigned TimeoutCyc = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        i_req, i_rvalid, i_done, d_req, d_wen, d_sign, d_done, d_err;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [7:0]  i_len, i_beat;
  logic [1:0]  d_size;
  logic        m_start, m_wen, m_ren, m_sign, m_rvalid, m_done;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_size;
  logic [7:0]  m_len;

  // Second instance, fixed priority, used only for the priority scenario.
  logic        p_i_req, p_d_req, p_m_done;
  logic        p_i_rvalid, p_i_done, p_d_done, p_d_err;
  logic        p_m_start, p_m_wen, p_m_ren, p_m_sign;
  logic [31:0] p_i_rdata, p_d_rdata, p_m_addr, p_m_wdata;
  logic [7:0]  p_i_beat, p_m_len;
  logic [1:0]  p_m_size;

  ysyx_25040111_mem_arb #(.PRIO_MODE(0), .TIMEOUT_CYC(TimeoutCyc)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_rdata(i_rdata),
    .i_rvalid(i_rvalid), .i_beat(i_beat), .i_done(i_done),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sign(d_sign), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_start(m_start), .m_wen(m_wen), .m_ren(m_ren), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size(m_size), .m_sign(m_sign), .m_len(m_len),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_done(m_done)
  );

  ysyx_25040111_mem_arb #(.PRIO_MODE(1), .TIMEOUT_CYC(TimeoutCyc)) dut_prio (
    .clock(clock), .reset(reset),
    .i_req(p_i_req), .i_addr(32'h3000_0900), .i_len(8'd0), .i_rdata(p_i_rdata),
    .i_rvalid(p_i_rvalid), .i_beat(p_i_beat), .i_done(p_i_done),
    .d_req(p_d_req), .d_wen(1'b0), .d_addr(32'h8000_0900), .d_wdata(32'h0),
    .d_size(2'b10), .d_sign(1'b0), .d_rdata(p_d_rdata), .d_done(p_d_done), .d_err(p_d_err),
    .m_start(p_m_start), .m_wen(p_m_wen), .m_ren(p_m_ren), .m_addr(p_m_addr),
    .m_wdata(p_m_wdata), .m_size(p_m_size), .m_sign(p_m_sign), .m_len(p_m_len),
    .m_rdata(32'h0), .m_rvalid(1'b0), .m_done(p_m_done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [1:0]  size;
    logic        sign;
    logic [7:0]  len;
    logic        chk_wdata;
    logic [31:0] wdata;
  } start_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  beat;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } dres_t;

  start_t      start_sb[$];
  beat_t       ibeat_sb[$];
  dres_t       dres_sb[$];
  logic [31:0] paddr_sb[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] out_vec();
    return {6'd0, i_rdata, i_rvalid, i_beat, i_done, d_rdata, d_done, d_err,
            m_start, m_wen, m_ren, m_addr, m_wdata, m_size, m_sign, m_len};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for a start pulse, then steps into the first WAIT cycle.
  task automatic wait_start(input bit prio, input string tag);
    int n = 0;
    @(negedge clock);
    while (!(prio ? p_m_start : m_start) && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!(prio ? p_m_start : m_start)) check_eq(tag, 0, 1);
    tick();
  endtask

  // Scoreboard: every DUT output event consumes the oldest expectation.
  always @(negedge clock) begin
    start_t e;
    beat_t  b;
    dres_t  r;
    if (m_start) begin
      if (start_sb.size() == 0) check_eq("start_unexpected", 1, 0);
      else begin
        e = start_sb.pop_front();
        check_eq("start_addr", m_addr, e.addr);
        check_eq("start_ctl", {m_wen, m_ren, m_size, m_sign, m_len},
                 {e.wen, e.ren, e.size, e.sign, e.len});
        if (e.chk_wdata) check_eq("start_wdata", m_wdata, e.wdata);
      end
    end
    if (i_rvalid) begin
      if (ibeat_sb.size() == 0) check_eq("ibeat_unexpected", 1, 0);
      else begin
        b = ibeat_sb.pop_front();
        check_eq("ibeat", {i_rdata, i_beat, i_done}, {b.data, b.beat, b.last});
      end
    end else if (i_done) begin
      check_eq("idone_without_beat", 1, 0);
    end
    if (d_done) begin
      if (dres_sb.size() == 0) check_eq("ddone_unexpected", 1, 0);
      else begin
        r = dres_sb.pop_front();
        check_eq("dres", {d_rdata, d_err}, {r.data, r.err});
      end
    end
    if (p_m_start) begin
      if (paddr_sb.size() == 0) check_eq("prio_start_unexpected", 1, 0);
      else check_eq("prio_grant_addr", p_m_addr, paddr_sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {i_req, d_req, d_wen, d_sign, m_rvalid, m_done, p_i_req, p_d_req, p_m_done} = '0;
    {i_addr, d_addr, d_wdata, m_rdata} = '0;
    i_len = '0;
    d_size = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("reset_outputs", out_vec(), 0);
    tick();
    reset = 1'b0;

    // Single D store, completion after five WAIT cycles.
    start_sb.push_back('{addr: 32'h8000_0010, wen: 1'b1, ren: 1'b0, size: 2'b10, sign: 1'b0,
                         len: 8'd0, chk_wdata: 1'b1, wdata: 32'hDEAD_BEEF});
    dres_sb.push_back('{data: 32'h0, err: 1'b0});
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h8000_0010; d_wdata = 32'hDEAD_BEEF;
    d_size = 2'b10; d_sign = 1'b0;
    @(negedge clock);
    check_eq("lat_req_cycle", m_start, 0);
    @(negedge clock);
    check_eq("lat_start", m_start, 1);
    tick();
    repeat (4) tick();
    m_done = 1'b1;
    @(negedge clock);
    check_eq("store_done", {d_done, d_err}, 2'b10);
    check_eq("store_hold", {m_wen, m_addr}, {1'b1, 32'h8000_0010});
    tick();
    m_done = 1'b0; d_req = 1'b0;

    // I burst of four beats; D load raised mid-burst must wait for i_done.
    start_sb.push_back('{addr: 32'h3000_0000, wen: 1'b0, ren: 1'b1, size: 2'b11, sign: 1'b0,
                         len: 8'd3, chk_wdata: 1'b0, wdata: 32'h0});
    for (int k = 0; k < 4; k++)
      ibeat_sb.push_back('{data: 32'h11 * (k + 1), beat: 8'(k), last: (k == 3)});
    i_req = 1'b1; i_addr = 32'h3000_0000; i_len = 8'd3;
    wait_start(1'b0, "burst_start_timeout");
    for (int k = 0; k < 4; k++) begin
      m_rvalid = 1'b1; m_rdata = 32'h11 * (k + 1); m_done = (k == 3);
      if (k == 1) begin
        start_sb.push_back('{addr: 32'h8000_0100, wen: 1'b0, ren: 1'b1, size: 2'b00,
                             sign: 1'b1, len: 8'd0, chk_wdata: 1'b0, wdata: 32'h0});
        dres_sb.push_back('{data: 32'hFFFF_FF80, err: 1'b0});
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h8000_0100; d_size = 2'b00; d_sign = 1'b1;
      end
      @(negedge clock);
      check_eq("burst_blocks_d", m_start, 0);
      tick();
    end
    m_rvalid = 1'b0; m_done = 1'b0; i_req = 1'b0;
    wait_start(1'b0, "d_after_burst_timeout");
    m_done = 1'b1; m_rdata = 32'hFFFF_FF80;
    @(negedge clock);
    check_eq("load_done", d_done, 1);
    tick();
    m_done = 1'b0; d_req = 1'b0;

    // Reset in the middle of a burst, then a stray completion.
    start_sb.push_back('{addr: 32'h3000_0040, wen: 1'b0, ren: 1'b1, size: 2'b11, sign: 1'b0,
                         len: 8'd3, chk_wdata: 1'b0, wdata: 32'h0});
    ibeat_sb.push_back('{data: 32'hA1, beat: 8'd0, last: 1'b0});
    ibeat_sb.push_back('{data: 32'hA2, beat: 8'd1, last: 1'b0});
    i_req = 1'b1; i_addr = 32'h3000_0040; i_len = 8'd3;
    wait_start(1'b0, "rst_burst_start_timeout");
    for (int k = 0; k < 2; k++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA1 + k;
      tick();
    end
    m_rvalid = 1'b0; reset = 1'b1; i_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_outputs", out_vec(), 0);
    check_eq("rst_state", dut.state_q, StIdle);
    check_eq("rst_beat", dut.beat_q, 0);
    tick();
    m_done = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h5555_5555;
    @(negedge clock);
    check_eq("stray_done", {i_done, d_done, i_rvalid}, 3'b000);
    tick();
    m_done = 1'b0; m_rvalid = 1'b0;

    // Held tie, round-robin: D, I, D, I.
    i_req = 1'b1; i_addr = 32'h3000_0100; i_len = 8'd0;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h8000_0200; d_size = 2'b10; d_sign = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) begin
        start_sb.push_back('{addr: 32'h8000_0200, wen: 1'b0, ren: 1'b1, size: 2'b10,
                             sign: 1'b0, len: 8'd0, chk_wdata: 1'b0, wdata: 32'h0});
        dres_sb.push_back('{data: 32'h5A00_0000 + n, err: 1'b0});
      end else begin
        start_sb.push_back('{addr: 32'h3000_0100, wen: 1'b0, ren: 1'b1, size: 2'b11,
                             sign: 1'b0, len: 8'd0, chk_wdata: 1'b0, wdata: 32'h0});
        ibeat_sb.push_back('{data: 32'h5A00_0000 + n, beat: 8'd0, last: 1'b1});
      end
      wait_start(1'b0, "tie_start_timeout");
      m_rvalid = 1'b1; m_done = 1'b1; m_rdata = 32'h5A00_0000 + n;
      @(negedge clock);
      check_eq("tie_owner_done", {i_done, d_done}, (n % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      m_rvalid = 1'b0; m_done = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;

    // Fixed priority: D keeps winning while both are held.
    p_i_req = 1'b1; p_d_req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      paddr_sb.push_back(32'h8000_0900);
      wait_start(1'b1, "prio_start_timeout");
      p_m_done = 1'b1;
      @(negedge clock);
      check_eq("prio_d_done", {p_i_done, p_d_done}, 2'b01);
      tick();
      p_m_done = 1'b0;
    end
    p_i_req = 1'b0; p_d_req = 1'b0;

`ifdef YSYX_25040111_ARB_TIMEOUT_EN
    // D load with no m_done: forced completion with error at the 16th WAIT cycle.
    begin
      bit early = 1'b0;
      start_sb.push_back('{addr: 32'h8000_0300, wen: 1'b0, ren: 1'b1, size: 2'b10,
                           sign: 1'b0, len: 8'd0, chk_wdata: 1'b0, wdata: 32'h0});
      dres_sb.push_back('{data: 32'h0, err: 1'b1});
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h8000_0300; d_size = 2'b10; d_sign = 1'b0;
      wait_start(1'b0, "to_start_timeout");
      for (int c = 1; c < int'(TimeoutCyc); c++) begin
        @(negedge clock);
        if (d_done) early = 1'b1;
        tick();
      end
      @(negedge clock);
      check_eq("to_early", early, 0);
      check_eq("to_done", {d_done, d_err}, 2'b11);
      tick();
      d_req = 1'b0; m_done = 1'b1;
      @(negedge clock);
      check_eq("to_late_done", d_done, 0);
      tick();
      m_done = 1'b0;
    end
`endif

    repeat (2) tick();
    check_eq("sb_drained", start_sb.size() + ibeat_sb.size() + dres_sb.size() + paddr_sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
